reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arb_pkg.sv | 17 +
 rtl/register_en_4.sv | 14 +
 rtl/reg_bank_arbiter.sv | 114 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arb_pkg.sv
// Shared types and sizing for the arbitrated register bank.
// The state enum is exported so checkers and benches can decode the debug state.
package reg_bank_arb_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GNT_A = 2'd2,
    ST_GNT_B = 2'd3
  } state_t;

endpackage

// File: rtl/register_en_4.sv
// 4-bit register with load enable and no reset.
// Contents are undefined until something writes it.
module register_en_4 (
  input  logic       i_clk,
  input  logic       i_en,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin write arbiter in front of a four-entry register bank.
// After reset the controller walks the bank to clear it before accepting requests.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_data_a,
  output logic              o_gnt_a,
  input  logic              i_req_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_gnt_b,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready,
  output logic [CNT_W-1:0]  o_wr_count,
  output state_t            o_state
);

  // Handshake: a requester raises req with addr/data and holds them; the
  // controller samples them in an IDLE cycle and answers with a one-cycle gnt
  // in the following cycle, during which the write happens. The requester must
  // drop req in the cycle after gnt, otherwise it is taken as a new request.

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic                rr_ptr_b;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [CNT_W-1:0]    wr_count;
  logic                gnt_a;
  logic                gnt_b;

  logic [NUM_REGS-1:0] bank_en;
  logic [DATA_W-1:0]   bank_d;
  logic [DATA_W-1:0]   bank_q [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rr_ptr_b <= 1'b0;
      wr_count <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(NUM_REGS - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          // A wins when alone or when the pointer favours it under contention.
          if (i_req_a && (!i_req_b || !rr_ptr_b)) begin
            state    <= ST_GNT_A;
            gnt_a    <= 1'b1;
            lat_addr <= i_addr_a;
            lat_data <= i_data_a;
            rr_ptr_b <= 1'b1;
          end else if (i_req_b) begin
            state    <= ST_GNT_B;
            gnt_b    <= 1'b1;
            lat_addr <= i_addr_b;
            lat_data <= i_data_b;
            rr_ptr_b <= 1'b0;
          end
        end
        ST_GNT_A, ST_GNT_B: begin
          wr_count <= wr_count + 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Enables are masked by reset so an interrupted grant cycle commits nothing.
  always_comb begin
    bank_en = '0;
    bank_d  = lat_data;
    if (!i_rst) begin
      case (state)
        ST_INIT: begin
          bank_en[init_cnt] = 1'b1;
          bank_d            = '0;
        end
        ST_GNT_A, ST_GNT_B: bank_en[lat_addr] = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
    register_en_4 u_reg (
      .i_clk (i_clk),
      .i_en  (bank_en[g]),
      .i_d   (bank_d),
      .o_q   (bank_q[g])
    );
  end

  assign o_rdata    = (state == ST_INIT) ? '0 : bank_q[i_raddr];
  assign o_ready    = (state == ST_IDLE);
  assign o_gnt_a    = gnt_a;
  assign o_gnt_b    = gnt_b;
  assign o_wr_count = wr_count;
  assign o_state    = state;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: init clear, single write, contention,
// round-robin fairness, reset during a grant and write-counter wrap.
module tb_reg_bank_arbiter;
  import reg_bank_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic [1:0]  addr_a, addr_b, raddr;
  logic [3:0]  data_a, data_b;
  logic        gnt_a, gnt_b;
  logic [3:0]  rdata;
  logic        ready;
  logic [7:0]  wr_count;
  state_t      st;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  reg_bank_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_a    (req_a),
    .i_addr_a   (addr_a),
    .i_data_a   (data_a),
    .o_gnt_a    (gnt_a),
    .i_req_b    (req_b),
    .i_addr_b   (addr_b),
    .i_data_b   (data_b),
    .o_gnt_b    (gnt_b),
    .i_raddr    (raddr),
    .o_rdata    (rdata),
    .o_ready    (ready),
    .o_wr_count (wr_count),
    .o_state    (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [3:0] exp);
    raddr = a;
    #1;
    check(tag, {28'd0, rdata}, {28'd0, exp});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  // Drives one request and waits (bounded) for its grant, then releases it.
  task automatic do_write(input logic sel_b, input logic [1:0] a, input logic [3:0] d);
    logic seen;
    seen = 1'b0;
    if (sel_b) begin
      req_b = 1'b1; addr_b = a; data_b = d;
    end else begin
      req_a = 1'b1; addr_a = a; data_a = d;
    end
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      if (sel_b ? gnt_b : gnt_a) seen = 1'b1;
    end
    check(sel_b ? "gnt_b_seen" : "gnt_a_seen", {31'd0, seen}, 32'd1);
    if (sel_b) req_b = 1'b0; else req_a = 1'b0;
    tick();
    check("gnt_one_cycle", {30'd0, gnt_b, gnt_a}, 32'd0);
  endtask

  // drivers / scenarios
  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0; raddr = '0;

    // Init sequence: ready low for exactly four cycles, bank cleared.
    tick();
    tick();
    check("rst_gnt", {30'd0, gnt_b, gnt_a}, 32'd0);
    check("rst_count", {24'd0, wr_count}, 32'd0);
    rst = 1'b0;
    check("init_ready_c0", {31'd0, ready}, 32'd0);
    read_chk("init_rdata_c0", 2'd0, 4'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("init_ready", {31'd0, ready}, 32'd0);
      read_chk("init_rdata", 2'(k), 4'h0);
    end
    tick();
    check("init_ready_done", {31'd0, ready}, 32'd1);
    for (int k = 0; k < 4; k++) read_chk("init_clear", 2'(k), 4'h0);
    check("init_count", {24'd0, wr_count}, 32'd0);

    // Single writer.
    do_write(1'b0, 2'd2, 4'b1010);
    read_chk("single_r2", 2'd2, 4'b1010);
    read_chk("single_r0", 2'd0, 4'h0);
    read_chk("single_r1", 2'd1, 4'h0);
    read_chk("single_r3", 2'd3, 4'h0);
    check("single_count", {24'd0, wr_count}, 32'd1);

    // Contention on the same address: A first, B two cycles later, B wins.
    do_reset();
    req_a = 1'b1; addr_a = 2'd1; data_a = 4'b0101;
    req_b = 1'b1; addr_b = 2'd1; data_b = 4'b1111;
    tick();
    check("cont_first", {30'd0, gnt_b, gnt_a}, 32'd1);
    req_a = 1'b0;
    tick();
    check("cont_gap", {30'd0, gnt_b, gnt_a}, 32'd0);
    read_chk("cont_mid_r1", 2'd1, 4'b0101);
    tick();
    check("cont_second", {30'd0, gnt_b, gnt_a}, 32'd2);
    req_b = 1'b0;
    tick();
    read_chk("cont_r1", 2'd1, 4'b1111);
    check("cont_count", {24'd0, wr_count}, 32'd2);

    // Fairness: both held for six grants; expect A,B,A,B,A,B.
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    req_a = 1'b1; addr_a = 2'd0; data_a = 4'h3;
    req_b = 1'b1; addr_b = 2'd1; data_b = 4'hC;
    for (int n = 0; n < 24 && exp_q.size() > 0; n++) begin
      tick();
      check("rr_no_dual", {31'd0, gnt_a & gnt_b}, 32'd0);
      if (gnt_a || gnt_b) begin
        check("rr_order", {30'd0, gnt_b, gnt_a}, {30'd0, exp_q.pop_front()});
      end
    end
    check("rr_timeout", exp_q.size(), 32'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    check("rr_count", {24'd0, wr_count}, 32'd6);
    read_chk("rr_r0", 2'd0, 4'h3);
    read_chk("rr_r1", 2'd1, 4'hC);

    // Reset during GNT_B: grant drops, INIT repeats, count cleared.
    do_reset();
    do_write(1'b0, 2'd0, 4'h7);
    check("rstg_pre_count", {24'd0, wr_count}, 32'd1);
    req_b = 1'b1; addr_b = 2'd3; data_b = 4'b0011;
    tick();
    check("rstg_gnt_b", {31'd0, gnt_b}, 32'd1);
    rst   = 1'b1;
    req_b = 1'b0;
    tick();
    check("rstg_no_gnt", {30'd0, gnt_b, gnt_a}, 32'd0);
    check("rstg_ready", {31'd0, ready}, 32'd0);
    check("rstg_state", {30'd0, st}, {30'd0, ST_INIT});
    check("rstg_count", {24'd0, wr_count}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rstg_still_init", {31'd0, ready}, 32'd0);
    tick();
    check("rstg_ready_back", {31'd0, ready}, 32'd1);
    read_chk("rstg_r3", 2'd3, 4'b0000);
    read_chk("rstg_r0", 2'd0, 4'b0000);
    check("rstg_count_after", {24'd0, wr_count}, 32'd0);

    // Counter wrap after 256 writes by A.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_write(1'b0, i[1:0], i[3:0]);
      if (i == 0)   check("wrap_count_1", {24'd0, wr_count}, 32'd1);
      if (i == 254) check("wrap_count_255", {24'd0, wr_count}, 32'd255);
    end
    check("wrap_count_0", {24'd0, wr_count}, 32'd0);
    read_chk("wrap_r3", 2'd3, 4'hF);
    read_chk("wrap_r2", 2'd2, 4'hE);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
